// File: rtl/proto_clone_engine.sv
// -----------------------------------------------------------------------------
// proto_clone_engine
//
// A small keyed registry of prototype words. Clients can register a word
// under a key, or ask for a clone of it. A clone returns the stored word with
// selected bits replaced by an override value. Lookups scan the occupied
// slots one per cycle, starting at slot 0. Registering a key that already
// exists overwrites that slot. A new key is appended at slot `count`, so
// insertion order is always preserved.
//
// Optional feature: define PROTO_CLONE_ENGINE_CLEAR_EN to add the `clr`
// input. This is a synchronous flush of the registry, and it is honoured
// only in IDLE.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reg_valid/reg_ready        registration handshake
//   reg_key, reg_data          key and prototype word to register
//   reg_err                    one-cycle pulse: new key dropped, registry full
//   clone_valid/clone_ready    clone-request handshake
//   clone_key                  lookup key
//   clone_mask, clone_ovr      override-bit mask and override value
//   rsp_valid/rsp_ready        clone-response handshake
//   rsp_data, rsp_hit          cloned word (0 on miss), key-found flag
//   count, full                occupied slot count, count==DEPTH
//   clr                        (PROTO_CLONE_ENGINE_CLEAR_EN only) registry flush
// -----------------------------------------------------------------------------
module proto_clone_engine #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int KEY_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef PROTO_CLONE_ENGINE_CLEAR_EN
    input  logic                       clr,
`endif
    input  logic                       reg_valid,
    output logic                       reg_ready,
    input  logic [KEY_W-1:0]           reg_key,
    input  logic [WIDTH-1:0]           reg_data,
    output logic                       reg_err,
    input  logic                       clone_valid,
    output logic                       clone_ready,
    input  logic [KEY_W-1:0]           clone_key,
    input  logic [WIDTH-1:0]           clone_mask,
    input  logic [WIDTH-1:0]           clone_ovr,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       rsp_hit,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEARCH  = 2'd1;
    localparam logic [1:0] ST_RESPOND = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_clone_q, is_clone_d;
    logic             reg_err_q, reg_err_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_hit_q, rsp_hit_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    // Request operands captured at acceptance; no reset needed
    logic [KEY_W-1:0] key_q, key_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ovr_q, ovr_d;

    logic [KEY_W-1:0] slot_key_q  [DEPTH];
    logic [WIDTH-1:0] slot_data_q [DEPTH];

    logic             wr_en;
    logic [IW-1:0]    wr_idx;
    logic             clr_act;
    logic             slot_hit;
    logic             last_slot;
    logic             full_int;

`ifdef PROTO_CLONE_ENGINE_CLEAR_EN
    assign clr_act = clr;
`else
    assign clr_act = 1'b0;
`endif

    assign full_int  = (cnt_q == CW'(DEPTH));
    // Slots at or above count hold stale data, so they must never match.
    assign slot_hit  = (idx_q < cnt_q) && (slot_key_q[idx_q[IW-1:0]] == key_q);
    // With an empty registry this is true at idx 0, giving a one-cycle miss.
    assign last_slot = ((idx_q + CW'(1)) >= cnt_q);

    assign reg_ready   = (state_q == ST_IDLE) && !clr_act;
    assign clone_ready = (state_q == ST_IDLE) && !clr_act && !reg_valid;
    assign reg_err     = reg_err_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_hit     = rsp_hit_q;
    assign rsp_data    = rsp_data_q;
    assign count       = cnt_q;
    assign full        = full_int;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        is_clone_d  = is_clone_q;
        reg_err_d   = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_data_d  = rsp_data_q;
        key_d       = key_q;
        data_d      = data_q;
        mask_d      = mask_q;
        ovr_d       = ovr_q;
        wr_en       = 1'b0;
        wr_idx      = cnt_q[IW-1:0];

        case (state_q)
            ST_IDLE: begin
                if (clr_act) begin
                    cnt_d = '0;
                end else if (reg_valid) begin
                    is_clone_d = 1'b0;
                    key_d      = reg_key;
                    data_d     = reg_data;
                    idx_d      = '0;
                    state_d    = ST_SEARCH;
                end else if (clone_valid) begin
                    is_clone_d = 1'b1;
                    key_d      = clone_key;
                    mask_d     = clone_mask;
                    ovr_d      = clone_ovr;
                    idx_d      = '0;
                    state_d    = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (slot_hit) begin
                    if (is_clone_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_hit_d   = 1'b1;
                        rsp_data_d  = (slot_data_q[idx_q[IW-1:0]] & ~mask_q) | (ovr_q & mask_q);
                        state_d     = ST_RESPOND;
                    end else begin
                        // Existing key: overwrite in place, count unchanged
                        wr_en   = 1'b1;
                        wr_idx  = idx_q[IW-1:0];
                        state_d = ST_IDLE;
                    end
                end else if (last_slot) begin
                    if (is_clone_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_hit_d   = 1'b0;
                        rsp_data_d  = '0;
                        state_d     = ST_RESPOND;
                    end else if (full_int) begin
                        reg_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        // Append at the end to keep insertion order
                        wr_en   = 1'b1;
                        wr_idx  = cnt_q[IW-1:0];
                        cnt_d   = cnt_q + CW'(1);
                        state_d = ST_IDLE;
                    end
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            ST_RESPOND: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            is_clone_q  <= 1'b0;
            reg_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            is_clone_q  <= is_clone_d;
            reg_err_q   <= reg_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // wr_en is derived from state, which reset holds in IDLE, so an aborted
    // operation can never write a slot.
    always_ff @(posedge clk) begin
        key_q  <= key_d;
        data_q <= data_d;
        mask_q <= mask_d;
        ovr_q  <= ovr_d;
        if (wr_en) begin
            slot_key_q[wr_idx]  <= key_q;
            slot_data_q[wr_idx] <= data_q;
        end
    end

endmodule

// File: tb/tb_proto_clone_engine.sv
module tb_proto_clone_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        reg_valid, reg_ready, reg_err;
    logic [7:0]  reg_key;
    logic [31:0] reg_data;
    logic        clone_valid, clone_ready;
    logic [7:0]  clone_key;
    logic [31:0] clone_mask, clone_ovr;
    logic        rsp_valid, rsp_ready, rsp_hit;
    logic [31:0] rsp_data;
    logic [3:0]  count;
    logic        full;

    int total = 0;
    int bad   = 0;
    int last_wait;

    always #5 clk = ~clk;

    proto_clone_engine #(.WIDTH(32), .DEPTH(8), .KEY_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef PROTO_CLONE_ENGINE_CLEAR_EN
        .clr(clr),
`endif
        .reg_valid(reg_valid), .reg_ready(reg_ready), .reg_key(reg_key),
        .reg_data(reg_data), .reg_err(reg_err),
        .clone_valid(clone_valid), .clone_ready(clone_ready), .clone_key(clone_key),
        .clone_mask(clone_mask), .clone_ovr(clone_ovr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_hit(rsp_hit), .count(count), .full(full)
    );

    typedef struct {
        bit          is_clone;
        logic [7:0]  key;
        logic [31:0] dat;   // reg data, or clone mask
        logic [31:0] ovr;
        logic        exp_hit;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_err;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_reg_err", 64'(reg_err), 64'd0);
        chk("rst_rsp", 64'({rsp_valid, rsp_hit, rsp_data}), 64'd0);
        chk("rst_reg_ready", 64'(reg_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_reg(input logic [7:0] k, input logic [31:0] d, input int exp_lat,
                          input int exp_err, input string nm);
        int lat, errs, w;
        @(negedge clk);
        reg_valid = 1'b1; reg_key = k; reg_data = d;
        w = 0;
        while (!reg_ready && w < 50) begin @(negedge clk); w++; end
        last_wait = w;
        @(posedge clk);
        #1 reg_valid = 1'b0; reg_key = ~k; reg_data = ~d;
        lat = 0; errs = 0;
        do begin
            @(posedge clk); #1; lat++;
            if (reg_err) errs++;
        end while (!reg_ready && lat < 50);
        @(posedge clk); #1;
        if (reg_err) errs++;
        chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_err"}, 64'(errs), 64'(exp_err));
    endtask

    // Wait for the response after acceptance, check it through a hold, release it
    task automatic finish_rsp(input logic exp_hit, input logic [31:0] exp_data, input int exp_lat,
                              input int hold, input string nm);
        int lat;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!rsp_valid && lat < 50);
        chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_rsp"}, 64'({rsp_hit, rsp_data}), 64'({exp_hit, exp_data}));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, "_hold"}, 64'({rsp_valid, rsp_hit, rsp_data}), 64'({1'b1, exp_hit, exp_data}));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk({nm, "_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    task automatic do_clone(input logic [7:0] k, input logic [31:0] m, input logic [31:0] o,
                            input logic exp_hit, input logic [31:0] exp_data, input int exp_lat,
                            input int hold, input string nm);
        int w;
        @(negedge clk);
        clone_valid = 1'b1; clone_key = k; clone_mask = m; clone_ovr = o;
        w = 0;
        while (!clone_ready && w < 50) begin @(negedge clk); w++; end
        @(posedge clk);
        #1 clone_valid = 1'b0; clone_key = ~k; clone_mask = ~m; clone_ovr = ~o;
        finish_rsp(exp_hit, exp_data, exp_lat, hold, nm);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; clr = 1'b0;
        reg_valid = 0; reg_key = 0; reg_data = 0;
        clone_valid = 0; clone_key = 0; clone_mask = 0; clone_ovr = 0;
        rsp_ready = 0;

        //            clone key    dat/mask      ovr           hit  exp_data      lat err cnt
        vecs.push_back('{0, 8'h11, 32'hDEADBEEF, 32'h0,        0, 32'h0,        1, 0, 1});
        vecs.push_back('{1, 8'h11, 32'h000000FF, 32'h00000042, 1, 32'hDEADBE42, 1, 0, 1});
        vecs.push_back('{0, 8'h05, 32'h00000001, 32'h0,        0, 32'h0,        1, 0, 2});
        vecs.push_back('{0, 8'h05, 32'h00000002, 32'h0,        0, 32'h0,        2, 0, 2});
        vecs.push_back('{1, 8'h05, 32'h00000000, 32'hFFFFFFFF, 1, 32'h00000002, 2, 0, 2});
        vecs.push_back('{0, 8'h01, 32'h10101010, 32'h0,        0, 32'h0,        2, 0, 3});
        vecs.push_back('{0, 8'h02, 32'h20202020, 32'h0,        0, 32'h0,        3, 0, 4});
        vecs.push_back('{0, 8'h03, 32'h30303030, 32'h0,        0, 32'h0,        4, 0, 5});
        vecs.push_back('{0, 8'h04, 32'h40404040, 32'h0,        0, 32'h0,        5, 0, 6});
        vecs.push_back('{0, 8'h06, 32'h60606060, 32'h0,        0, 32'h0,        6, 0, 7});
        vecs.push_back('{0, 8'h07, 32'h70707070, 32'h0,        0, 32'h0,        7, 0, 8});
        vecs.push_back('{0, 8'h09, 32'h90909090, 32'h0,        0, 32'h0,        8, 1, 8});
        vecs.push_back('{1, 8'h09, 32'hFFFFFFFF, 32'h12345678, 0, 32'h0,        8, 0, 8});
        vecs.push_back('{1, 8'h07, 32'hFFFF0000, 32'h12345678, 1, 32'h12347070, 8, 0, 8});
        vecs.push_back('{1, 8'h11, 32'h00000000, 32'h0,        1, 32'hDEADBEEF, 1, 0, 8});
        vecs.push_back('{0, 8'h03, 32'h00000033, 32'h0,        0, 32'h0,        5, 0, 8});
        vecs.push_back('{1, 8'h03, 32'hFFFF0000, 32'hAAAA5555, 1, 32'hAAAA0033, 5, 0, 8});

        apply_reset();

        foreach (vecs[i]) begin
            if (vecs[i].is_clone)
                do_clone(vecs[i].key, vecs[i].dat, vecs[i].ovr, vecs[i].exp_hit,
                         vecs[i].exp_data, vecs[i].exp_lat, 0, $sformatf("v%0d_clone", i));
            else
                do_reg(vecs[i].key, vecs[i].dat, vecs[i].exp_lat, vecs[i].exp_err,
                       $sformatf("v%0d_reg", i));
            if (i == 0) chk("first_accept_wait", 64'(last_wait), 64'd0);
            chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].exp_cnt));
        end
        chk("full_at_8", 64'(full), 64'd1);

        // Simultaneous registration and clone: registration must win
        apply_reset();
        @(negedge clk);
        reg_valid = 1'b1; reg_key = 8'h31; reg_data = 32'h31313131;
        clone_valid = 1'b1; clone_key = 8'h31; clone_mask = 32'h0; clone_ovr = 32'h0;
        #1;
        chk("sim_ready", 64'({reg_ready, clone_ready}), 64'b10);
        @(posedge clk);
        #1 reg_valid = 1'b0;
        seen = 0;
        while (!reg_ready && seen < 50) begin @(posedge clk); #1; seen++; end
        chk("sim_reg_lat", 64'(seen), 64'd1);
        @(posedge clk);
        #1 clone_valid = 1'b0;
        finish_rsp(1'b1, 32'h31313131, 1, 5, "sim_clone");
        chk("sim_count", 64'(count), 64'd1);

        // Reset during a clone search
        do_reg(8'h21, 32'hA1, 1, 0, "pre_a");
        do_reg(8'h22, 32'hA2, 2, 0, "pre_b");
        do_reg(8'h23, 32'hA3, 3, 0, "pre_c");
        @(negedge clk);
        clone_valid = 1'b1; clone_key = 8'h23; clone_mask = 0; clone_ovr = 0;
        @(posedge clk);
        #1 clone_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_state", 64'({rsp_valid, count, full}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (rsp_valid) seen++; end
        chk("abort_no_rsp", 64'(seen), 64'd0);
        do_clone(8'h23, 32'h0, 32'h0, 1'b0, 32'h0, 1, 0, "abort_miss");

`ifdef PROTO_CLONE_ENGINE_CLEAR_EN
        do_reg(8'h41, 32'h41, 1, 0, "clr_a");
        do_reg(8'h42, 32'h42, 1, 0, "clr_b");
        do_reg(8'h43, 32'h43, 2, 0, "clr_c");
        chk("clr_pre_count", 64'(count), 64'd3);
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("clr_ready", 64'({reg_ready, clone_ready}), 64'b00);
        @(posedge clk);
        #1 clr = 1'b0;
        chk("clr_count", 64'(count), 64'd0);
        do_clone(8'h42, 32'h0, 32'h0, 1'b0, 32'h0, 1, 0, "clr_miss");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/proto_clone_engine.md
PROTO_CLONE_ENGINE -- requirements
Module: proto_clone_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bit width of a prototype word.
REQ-002 SHALL have parameter DEPTH, default 8, number of registry slots (>=2).
REQ-003 SHALL have parameter KEY_W, default 8, bit width of a prototype key.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports reg_valid/reg_ready  input/output  1/1  registration handshake.
REQ-007 SHALL have ports reg_key, reg_data  input  KEY_W, WIDTH  key and prototype word to register.
REQ-008 SHALL have port reg_err  output  1  one-cycle pulse: registration dropped, registry full.
REQ-009 SHALL have ports clone_valid/clone_ready  input/output  1/1  clone-request handshake.
REQ-010 SHALL have ports clone_key, clone_mask, clone_ovr  input  KEY_W, WIDTH, WIDTH  lookup key, override-bit mask, override value.
REQ-011 SHALL have ports rsp_valid/rsp_ready  output/input  1/1  clone-response handshake.
REQ-012 SHALL have ports rsp_data, rsp_hit  output  WIDTH, 1  cloned word, key-found flag.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  number of occupied slots.
REQ-014 SHALL have port full  output  1  high when count==DEPTH.

Function
REQ-015 SHALL implement FSM states IDLE, SEARCH, RESPOND; registration runs IDLE->SEARCH->IDLE, clone runs IDLE->SEARCH->RESPOND->IDLE.
REQ-016 reg_ready SHALL be high only in IDLE; clone_ready SHALL be high only in IDLE with reg_valid low (registration wins a simultaneous request).
REQ-017 Accepted key/data/mask/ovr SHALL be captured at the acceptance edge; input changes afterwards SHALL have no effect.
REQ-018 SEARCH SHALL compare one slot per cycle, index 0 upward over slots 0..count-1; no slot at or above count SHALL ever match.
REQ-019 Clone hit at slot k: rsp_valid SHALL rise after edge A+k+1 (A = acceptance edge), rsp_hit=1, rsp_data=(proto & ~clone_mask) | (clone_ovr & clone_mask).
REQ-020 Clone miss: rsp_valid SHALL rise after edge A+max(count,1), rsp_hit=0, rsp_data=0.
REQ-021 rsp_valid, rsp_data, rsp_hit SHALL hold stable until rsp_ready is sampled high; FSM returns to IDLE on that edge.
REQ-022 Registration hit at slot k SHALL overwrite slot k's data at edge A+k+1 with count unchanged.
REQ-023 Registration miss, not full: data and key SHALL be written to slot count and count SHALL increment at the final SEARCH edge.
REQ-024 Registration miss, full: registry SHALL be unchanged and reg_err SHALL pulse high for exactly one cycle.
REQ-025 Slots SHALL never be reordered; insertion order SHALL be preserved.
REQ-026 Duplicate keys SHALL never exist, since registration of an existing key always overwrites.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, count=0, full=0, reg_err=0, rsp_valid=0, rsp_hit=0, rsp_data=0; slot contents SHALL need no reset.
REQ-028 Reset asserted mid-SEARCH or mid-RESPOND SHALL abandon the operation with no response and no slot write.
REQ-029 First request acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro PROTO_CLONE_ENGINE_CLEAR_EN SHALL add input port clr (1 bit, synchronous registry flush).
REQ-031 With the macro defined, clr high in IDLE SHALL set count=0 at the next edge and deassert reg_ready/clone_ready that cycle; clr SHALL be ignored outside IDLE.
REQ-032 Without the macro, port clr SHALL be absent and count SHALL only return to 0 via rst_n.

Verification
REQ-033 Register key 0x11 data 0xDEADBEEF, clone key 0x11 mask 0x000000FF ovr 0x00000042 -> rsp_hit=1, rsp_data=0xDEADBE42, rsp_valid after A+1.
REQ-034 Register keys 0x01..0x08 (DEPTH=8), then register 0x09 -> reg_err one-cycle pulse, count=8, full=1; clone 0x09 -> rsp_hit=0, rsp_data=0, latency 8 edges.
REQ-035 Register 0x05=0x1 then 0x05=0x2, clone 0x05 mask 0 -> rsp_data=0x2, count=1.
REQ-036 reg_valid and clone_valid asserted together in IDLE -> registration accepted first, clone accepted after return to IDLE; hold rsp_ready low 5 cycles -> rsp_* stable throughout.
REQ-037 Assert rst_n low during SEARCH of a clone -> no rsp_valid, count=0, next clone of same key misses.
REQ-038 With PROTO_CLONE_ENGINE_CLEAR_EN, register 3 keys, pulse clr in IDLE -> count=0, subsequent clone of any key misses.
